serial_sub4: RTL
================

SERIAL_SUB4 -- requirements
Module: serial_sub4

Interface
REQ-001 Parameter: WIDTH, default 4, operand/result width in bits; legal range 2..16.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request pulse; sampled on rising clk.
REQ-005 a  input  WIDTH  minuend; sampled with accepted start only.
REQ-006 b  input  WIDTH  subtrahend; sampled with accepted start only.
REQ-007 busy  output  1  high while an operation is in progress.
REQ-008 done  output  1  one-cycle pulse marking a valid result.
REQ-009 d  output  WIDTH  difference a-b, modulo 2^WIDTH.
REQ-010 bout  output  1  borrow out; 1 when a < b (unsigned).
REQ-011 One clock, clk; reset rst_n is asynchronous and active-low; no other clock or reset domain.

Function
REQ-012 The block SHALL compute a-b bit-serially, LSB first, one bit per clock, using a single 1-bit full-subtractor cell and a borrow flip-flop.
REQ-013 Per-bit rule: diff = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-014 FSM states: IDLE, RUN, DONE; encoding free.
REQ-015 IDLE: start=1 at edge E0 -> latch a, b into shift registers, clear borrow to 0, clear bit counter, enter RUN, busy=1.
REQ-016 RUN: each edge processes one bit, shifts operand registers right, shifts diff into result register MSB, increments counter.
REQ-017 After WIDTH RUN edges (edge E_WIDTH): transfer result to d, final borrow to bout, enter DONE, done=1, busy=0.
REQ-018 DONE: lasts exactly one cycle; next edge returns to IDLE, done=0.
REQ-019 Latency: done high in the cycle following edge E_WIDTH, i.e. WIDTH+1 clocks after the start-sampling edge (counting E0).
REQ-020 start while busy=1 or in DONE SHALL be ignored; operands not re-sampled; operation unaffected.
REQ-021 start in the cycle after done falls (IDLE) SHALL be accepted; max throughput one result per WIDTH+2 clocks.
REQ-022 a, b changes after acceptance SHALL NOT affect the result.
REQ-023 d and bout SHALL change only at edge E_WIDTH and hold otherwise, including across IDLE.
REQ-024 All outputs registered; no combinational path from inputs to outputs.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, d=0, bout=0, borrow=0, counter=0, independent of clk.
REQ-026 Reset asserted mid-RUN SHALL abort the operation; no done pulse issued for it; after release the block accepts a new start.
REQ-027 Reset release is synchronised externally; the first start is accepted on the first rising edge with rst_n=1.

Verification
REQ-028 a=9, b=3, start one cycle -> busy 4 cycles, done pulse at E0+4, d=6, bout=0.
REQ-029 a=3, b=9 -> d=0xA, bout=1; a=0, b=0 -> d=0, bout=0; a=0xF, b=0xF -> d=0, bout=0; a=0, b=1 -> d=0xF, bout=1.
REQ-030 a=5, b=2 accepted; start held high with a=0xF, b=0 during RUN and DONE -> single done with d=3, bout=0; new operation accepted only once in IDLE.
REQ-031 a=0xC, b=0x4 accepted; rst_n pulsed low after 2 RUN edges -> outputs 0 immediately, no done; then a=0x7, b=0x8 -> d=0xF, bout=1.
REQ-032 WIDTH=8: a=0x10, b=0x01 -> done 8 edges after E0, d=0x0F, bout=0; random 1000-vector compare against a-b reference, back-to-back starts.

Source files
------------

// File: rtl/serial_sub4.sv
// serial_sub4: bit-serial unsigned subtractor, d = a - b (mod 2^WIDTH).
// Uses one full-subtractor cell and a borrow flop; LSB first, one bit per clock.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   start  - request; accepted only in IDLE
//   a, b   - minuend / subtrahend, sampled with an accepted start
//   busy   - high while bits are being processed
//   done   - one-cycle pulse when d/bout are updated
//   d      - difference, updated only at the end of an operation
//   bout   - final borrow, 1 when a < b (unsigned)
module serial_sub4 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned RW = WIDTH - 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    // Holds the WIDTH-1 low result bits; the last bit goes straight into d.
    logic [RW-1:0]    res_q, res_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             diff_c;
    logic             br_nx_c;

    // Full-subtractor cell on the current LSBs
    always_comb begin
        diff_c  = a_q[0] ^ b_q[0] ^ br_q;
        br_nx_c = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        bout_d  = bout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                // New diff bit enters at the MSB of the result register
                res_d = (res_q >> 1) | (RW'(diff_c) << (RW - 1));
                br_d  = br_nx_c;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    d_d     = {diff_c, res_q};
                    bout_d  = br_nx_c;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign d    = d_q;
    assign bout = bout_q;

endmodule
